// File: rtl/tn_bus_pkg.sv
// Shared types for the SERV memory arbiter slice.
// Arbiter states, grant owner and the IO address decode helper.
package tn_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_IBUS = 1'b0,
      GNT_DBUS = 1'b1
   } grant_t;

   function automatic logic is_io(input logic [31:0] adr,
                                  input logic [4:0]  sel_bit);
      return adr[sel_bit];
   endfunction

endpackage

// File: rtl/tn_mem_arbiter.sv
// Shares one synchronous RAM between SERV ibus and dbus,
// with a small GPIO output register on the dbus IO window.
module tn_mem_arbiter
   import tn_bus_pkg::*;
#(
   parameter int RAM_AW     = 8,
   parameter int IO_SEL_BIT = 8,
   parameter int GPIO_W     = 3
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic [31:0]       ibus_adr,
   input  logic              ibus_cyc,
   output logic [31:0]       ibus_rdt,
   output logic              ibus_ack,
   input  logic [31:0]       dbus_adr,
   input  logic [31:0]       dbus_dat,
   input  logic [3:0]        dbus_sel,
   input  logic              dbus_we,
   input  logic              dbus_cyc,
   output logic [31:0]       dbus_rdt,
   output logic              dbus_ack,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_ce,
   output logic [3:0]        ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [GPIO_W-1:0] gpio_out
);

   localparam logic [4:0] IO_BIT = IO_SEL_BIT[4:0];

   arb_state_t state;
   grant_t     last_grant;
   grant_t     gnt;
   logic       io_q;
   logic       we_q;
   logic       sel0_q;

   logic ib_el;
   logic db_el;
   logic pick_d;
   logic d_io;
   logic unused_adr;

   // A requester whose ack is high this cycle is still holding cyc
   // for the finished transfer, so it must not be granted again.
   assign ib_el  = ibus_cyc & ~ibus_ack;
   assign db_el  = dbus_cyc & ~dbus_ack;
   assign pick_d = db_el & (~ib_el | (last_grant == GNT_IBUS));
   assign d_io   = is_io(dbus_adr, IO_BIT);

   assign unused_adr = ^{ibus_adr[31:RAM_AW+2], ibus_adr[1:0]};

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state      <= IDLE;
         last_grant <= GNT_DBUS;
         gnt        <= GNT_IBUS;
         io_q       <= 1'b0;
         we_q       <= 1'b0;
         sel0_q     <= 1'b0;
         ibus_ack   <= 1'b0;
         dbus_ack   <= 1'b0;
         ibus_rdt   <= '0;
         dbus_rdt   <= '0;
         ram_addr   <= '0;
         ram_ce     <= 1'b0;
         ram_we     <= 4'h0;
         ram_wdata  <= '0;
         gpio_out   <= '0;
      end else begin
         ibus_ack <= 1'b0;
         dbus_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ib_el | db_el) begin
                  state     <= ISSUE;
                  ram_wdata <= dbus_dat;
                  we_q      <= dbus_we;
                  sel0_q    <= dbus_sel[0];
                  if (pick_d) begin
                     gnt        <= GNT_DBUS;
                     last_grant <= GNT_DBUS;
                     io_q       <= d_io;
                     ram_addr   <= dbus_adr[RAM_AW+1:2];
                     ram_ce     <= ~d_io;
                     ram_we     <= (dbus_we & ~d_io) ? dbus_sel : 4'h0;
                  end else begin
                     gnt        <= GNT_IBUS;
                     last_grant <= GNT_IBUS;
                     io_q       <= 1'b0;
                     ram_addr   <= ibus_adr[RAM_AW+1:2];
                     ram_ce     <= 1'b1;
                     ram_we     <= 4'h0;
                  end
               end
            end
            ISSUE: begin
               ram_ce <= 1'b0;
               ram_we <= 4'h0;
               state  <= CAPTURE;
            end
            CAPTURE: begin
               state <= IDLE;
               if (gnt == GNT_IBUS) begin
                  ibus_rdt <= ram_rdata;
                  ibus_ack <= 1'b1;
               end else begin
                  dbus_ack <= 1'b1;
                  if (io_q) begin
                     if (!we_q)
                        dbus_rdt <= 32'(gpio_out);
                     else if (sel0_q)
                        gpio_out <= ram_wdata[GPIO_W-1:0];
                  end else if (!we_q) begin
                     dbus_rdt <= ram_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tn_mem_arbiter.sv
// Randomized bench for tn_mem_arbiter against a transaction-level model.
// Includes a behavioural RAM macro with one-cycle read latency.
module tb_tn_mem_arbiter;

   logic        clk = 1'b0;
   logic        i_rst;
   logic [31:0] ibus_adr;
   logic        ibus_cyc;
   logic [31:0] ibus_rdt;
   logic        ibus_ack;
   logic [31:0] dbus_adr;
   logic [31:0] dbus_dat;
   logic [3:0]  dbus_sel;
   logic        dbus_we;
   logic        dbus_cyc;
   logic [31:0] dbus_rdt;
   logic        dbus_ack;
   logic [7:0]  ram_addr;
   logic        ram_ce;
   logic [3:0]  ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [2:0]  gpio_out;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram     [0:255];
   logic [31:0] ref_mem [0:255];
   logic [2:0]  ref_gpio;
   logic [31:0] ref_irdt;
   logic [31:0] ref_drdt;
   bit          ref_lg_d;

   always #5 clk = ~clk;

   tn_mem_arbiter #(
      .RAM_AW(8), .IO_SEL_BIT(8), .GPIO_W(3)
   ) dut (
      .clk(clk), .i_rst(i_rst),
      .ibus_adr(ibus_adr), .ibus_cyc(ibus_cyc),
      .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
      .dbus_adr(dbus_adr), .dbus_dat(dbus_dat),
      .dbus_sel(dbus_sel), .dbus_we(dbus_we),
      .dbus_cyc(dbus_cyc), .dbus_rdt(dbus_rdt),
      .dbus_ack(dbus_ack),
      .ram_addr(ram_addr), .ram_ce(ram_ce),
      .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .gpio_out(gpio_out)
   );

   always @(posedge clk) begin
      if (ram_ce) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram[ram_addr][8*b+:8] <= ram_wdata[8*b+:8];
         ram_rdata <= ram[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (ibus_ack && dbus_ack)
         check("both_ack", {31'b0, ibus_ack & dbus_ack}, 32'h0);

   task automatic model_i(input logic [31:0] ia);
      ref_irdt = ref_mem[ia[9:2]];
   endtask

   task automatic model_d(input logic [31:0] da, input bit we,
                          input logic [3:0] sel, input logic [31:0] dat);
      logic [7:0] idx;
      idx = da[9:2];
      if (da[8]) begin
         if (!we) ref_drdt = {29'b0, ref_gpio};
         else if (sel[0]) ref_gpio = dat[2:0];
      end else if (we) begin
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[idx][8*b+:8] = dat[8*b+:8];
      end else begin
         ref_drdt = ref_mem[idx];
      end
   endtask

   task automatic xact(input bit di, input logic [31:0] ia,
                       input bit dd, input logic [31:0] da,
                       input bit dwe, input logic [3:0] ds,
                       input logic [31:0] dt);
      bit   first_d;
      int   ic, dc, last;
      logic exp_ce;
      logic [3:0] exp_we;
      logic [7:0] exp_addr;
      first_d  = dd && (!di || !ref_lg_d);
      ic       = di ? (first_d ? 6 : 3) : -1;
      dc       = dd ? (first_d ? 3 : 6) : -1;
      last     = (ic > dc) ? ic : dc;
      if (last < 1) last = 1;
      exp_ce   = first_d ? !da[8] : 1'b1;
      exp_we   = (first_d && dwe && !da[8]) ? ds : 4'h0;
      exp_addr = first_d ? da[9:2] : ia[9:2];
      if (first_d) begin
         model_d(da, dwe, ds, dt);
         if (di) model_i(ia);
      end else begin
         if (di) model_i(ia);
         if (dd) model_d(da, dwe, ds, dt);
      end
      if (di && dd) ref_lg_d = !first_d;
      else if (dd) ref_lg_d = 1'b1;
      else if (di) ref_lg_d = 1'b0;
      ibus_cyc = di; ibus_adr = ia;
      dbus_cyc = dd; dbus_adr = da;
      dbus_we = dwe; dbus_sel = ds; dbus_dat = dt;
      for (int c = 1; c <= last + 1; c++) begin
         @(posedge clk); #1;
         if (c == 1 && (di || dd)) begin
            check("ram_ce", {31'b0, ram_ce}, {31'b0, exp_ce});
            check("ram_we", {28'b0, ram_we}, {28'b0, exp_we});
            check("ram_addr", {24'b0, ram_addr}, {24'b0, exp_addr});
         end
         check("acks", {30'b0, ibus_ack, dbus_ack},
               {30'b0, c == ic, c == dc});
         if (c == ic) check("ibus_rdt", ibus_rdt, ref_irdt);
         if (c == dc) check("dbus_rdt", dbus_rdt, ref_drdt);
         if (c == ic + 1) ibus_cyc = 1'b0;
         if (c == dc + 1) dbus_cyc = 1'b0;
      end
      check("gpio", {29'b0, gpio_out}, {29'b0, ref_gpio});
   endtask

   initial begin
      logic [31:0] ra, rd;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = $urandom;
         ref_mem[i] = ram[i];
      end
      ram[4] = 32'h0000_0513;
      ref_mem[4] = 32'h0000_0513;
      ref_gpio = 3'b0; ref_irdt = '0; ref_drdt = '0; ref_lg_d = 1'b1;
      ram_rdata = '0;
      i_rst = 1'b1;
      ibus_cyc = 0; ibus_adr = '0;
      dbus_cyc = 0; dbus_adr = '0; dbus_dat = '0;
      dbus_sel = '0; dbus_we = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ce", {31'b0, ram_ce}, 32'h0);
      check("rst_we", {28'b0, ram_we}, 32'h0);
      check("rst_acks", {30'b0, ibus_ack, dbus_ack}, 32'h0);
      check("rst_irdt", ibus_rdt, 32'h0);
      check("rst_drdt", dbus_rdt, 32'h0);
      check("rst_gpio", {29'b0, gpio_out}, 32'h0);
      check("rst_wdata", ram_wdata, 32'h0);
      i_rst = 1'b0;

      xact(1, 32'h10, 1, 32'h30, 0, 4'hF, 32'h0);
      xact(1, 32'h10, 0, 32'h0, 0, 4'h0, 32'h0);
      xact(0, 32'h0, 1, 32'h20, 1, 4'b0101, 32'hAABB_CCDD);
      xact(0, 32'h0, 1, 32'h20, 0, 4'hF, 32'h0);
      xact(0, 32'h0, 1, 32'h100, 1, 4'b0001, 32'h5);
      xact(0, 32'h0, 1, 32'h100, 1, 4'b0000, 32'h2);
      xact(0, 32'h0, 1, 32'h104, 0, 4'hF, 32'h0);
      xact(1, 32'hFFFF_FC10, 1, 32'h1234_5E10, 0, 4'hF, 32'h0);

      for (int n = 0; n < 300; n++) begin
         ra = $urandom;
         rd = $urandom;
         rd[8] = ($urandom_range(3) == 0);
         xact($urandom_range(1) == 1, ra, $urandom_range(1) == 1, rd,
              $urandom_range(1) == 1, 4'($urandom), $urandom);
      end

      xact(0, 32'h0, 1, 32'h100, 1, 4'b0001, 32'h6);
      ibus_cyc = 1; ibus_adr = 32'h40;
      dbus_cyc = 1; dbus_adr = 32'h100; dbus_we = 1;
      dbus_sel = 4'b0001; dbus_dat = 32'h1;
      @(posedge clk); #1;
      i_rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_ce", {31'b0, ram_ce}, 32'h0);
      check("mid_rst_we", {28'b0, ram_we}, 32'h0);
      check("mid_rst_acks", {30'b0, ibus_ack, dbus_ack}, 32'h0);
      check("mid_rst_addr", {24'b0, ram_addr}, 32'h0);
      check("mid_rst_irdt", ibus_rdt, 32'h0);
      check("mid_rst_drdt", dbus_rdt, 32'h0);
      check("mid_rst_gpio", {29'b0, gpio_out}, 32'h0);
      i_rst = 1'b0; ibus_cyc = 0; dbus_cyc = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("post_rst_acks", {30'b0, ibus_ack, dbus_ack}, 32'h0);
      end
      ref_gpio = 3'b0; ref_irdt = '0; ref_drdt = '0; ref_lg_d = 1'b1;

      xact(1, 32'h10, 1, 32'h104, 0, 4'hF, 32'h0);
      for (int n = 0; n < 50; n++) begin
         ra = $urandom;
         rd = $urandom;
         rd[8] = ($urandom_range(3) == 0);
         xact($urandom_range(1) == 1, ra, $urandom_range(1) == 1, rd,
              $urandom_range(1) == 1, 4'($urandom), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
